clk_mode_ctrl: RTL and testbench



---
 rtl/clk_mode_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clk_mode_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clk_mode_ctrl.sv
// Key-driven mode controller for the clock/stopwatch datapath.
// Registers the mode flags, runs alarm setting and the PAUSE idle timeout.
module clk_mode_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500000000,
  parameter int unsigned TO_W        = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_stop,
  input  logic       key_clear,
  input  logic       key_pre,
  input  logic       key_mode,
  output logic       CLK_R,
  output logic       TIME_R,
  output logic       PAUSE_R,
  output logic       STOP_R,
  output logic       CLEAR_R,
  output logic       PRE_R,
  output logic       alarm_set,
  output logic       alarm_ready,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_STOP  = 3'd3,
    S_CLEAR = 3'd4,
    S_PRE   = 3'd5,
    S_ALARM = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX = '1;

  state_t state_q;
  state_t state_d;

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  logic [5:0] flags_q;
  logic [5:0] flags_d;
  logic       ready_d;

  logic key_any;
  logic w_clear;
  logic w_stop;
  logic w_pre;
  logic w_start;
  logic w_mode;

  // Fixed-priority key arbitration: clear > stop > pre > start > mode.
  always_comb begin
    key_any = key_clear | key_stop | key_pre
            | key_start | key_mode;
    w_clear = key_clear;
    w_stop  = key_stop  & ~key_clear;
    w_pre   = key_pre   & ~key_stop & ~key_clear;
    w_start = key_start & ~key_pre
            & ~key_stop & ~key_clear;
    w_mode  = key_mode  & ~key_start & ~key_pre
            & ~key_stop & ~key_clear;
  end

  // Next-state, idle counter and alarm confirm decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ready_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_start)     state_d = S_RUN;
        else if (w_mode) state_d = S_ALARM;
      end
      S_RUN: begin
        if (w_start)     state_d = S_PAUSE;
        else if (w_stop) state_d = S_STOP;
      end
      S_PAUSE: begin
        if (w_start) begin
          state_d = S_RUN;
        end else if (w_stop) begin
          state_d = S_STOP;
        end else if (!key_any) begin
          if (cnt_q == TO_LAST)
            state_d = S_STOP;
          else if (cnt_q != TO_MAX)
            cnt_d = cnt_q + TO_W'(1);
          else
            cnt_d = cnt_q;
        end
      end
      S_STOP: begin
        if (w_clear)      state_d = S_CLEAR;
        else if (w_pre)   state_d = S_PRE;
        else if (w_start) state_d = S_RUN;
        else if (w_mode)  state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (w_pre)        state_d = S_PRE;
        else if (w_start) state_d = S_RUN;
        else if (w_mode)  state_d = S_IDLE;
      end
      S_PRE: begin
        if (w_clear)      state_d = S_CLEAR;
        else if (w_start) state_d = S_RUN;
        else if (w_mode)  state_d = S_IDLE;
      end
      S_ALARM: begin
        if (w_start) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else if (w_mode) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != S_PAUSE)
      cnt_d = '0;
  end

  // Flag pattern for the state being entered.
  always_comb begin
    flags_d = 6'b100000;
    unique case (state_d)
      S_IDLE:  flags_d = 6'b100000;
      S_RUN:   flags_d = 6'b110000;
      S_PAUSE: flags_d = 6'b111000;
      S_STOP:  flags_d = 6'b110100;
      S_CLEAR: flags_d = 6'b110110;
      S_PRE:   flags_d = 6'b110111;
      S_ALARM: flags_d = 6'b000000;
      default: flags_d = 6'b100000;
    endcase
  end

  // State, counter and every output are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      flags_q     <= 6'b100000;
      alarm_set   <= 1'b0;
      alarm_ready <= 1'b0;
      state_code  <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      alarm_set   <= (state_d == S_ALARM);
      alarm_ready <= ready_d;
      state_code  <= state_d;
    end
  end

  assign CLK_R   = flags_q[5];
  assign TIME_R  = flags_q[4];
  assign PAUSE_R = flags_q[3];
  assign STOP_R  = flags_q[2];
  assign CLEAR_R = flags_q[1];
  assign PRE_R   = flags_q[0];

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// Bench for clk_mode_ctrl: table-driven reference model feeding a
// scoreboard queue, checked by an independent monitor each cycle.
module tb_clk_mode_ctrl;

  localparam int T = 8;

  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_CLR  = 5'b10000;
  localparam logic [4:0] K_STP  = 5'b01000;
  localparam logic [4:0] K_PRE  = 5'b00100;
  localparam logic [4:0] K_STA  = 5'b00010;
  localparam logic [4:0] K_MOD  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b0;
  logic       key_stop = 1'b0;
  logic       key_clear = 1'b0;
  logic       key_pre = 1'b0;
  logic       key_mode = 1'b0;
  logic       CLK_R, TIME_R, PAUSE_R, STOP_R, CLEAR_R, PRE_R;
  logic       alarm_set, alarm_ready;
  logic [2:0] state_code;

  always #5 clk = ~clk;

  clk_mode_ctrl #(.TIMEOUT_CYC(T), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .key_start(key_start), .key_stop(key_stop),
    .key_clear(key_clear), .key_pre(key_pre),
    .key_mode(key_mode),
    .CLK_R(CLK_R), .TIME_R(TIME_R), .PAUSE_R(PAUSE_R),
    .STOP_R(STOP_R), .CLEAR_R(CLEAR_R), .PRE_R(PRE_R),
    .alarm_set(alarm_set), .alarm_ready(alarm_ready),
    .state_code(state_code)
  );

  // Transition table: nxt[state][key], key 0..4 = clear,stop,pre,start,mode.
  int         nxt [7][5];
  logic [5:0] ftab [7];

  logic [10:0] exp_q [$];
  string       tag_q [$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          m_st = 0;
  int          m_cnt = 0;
  string       cur_tag = "reset";

  logic [10:0] e_v;
  logic [10:0] g_v;
  string       e_t;

  task automatic step(input logic [4:0] k, input logic r);
    int   w;
    int   ns;
    logic rdy;
    @(negedge clk);
    {key_clear, key_stop, key_pre, key_start, key_mode} = k;
    rst = r;
    rdy = 1'b0;
    ns  = m_st;
    w   = -1;
    if (r) begin
      ns    = 0;
      m_cnt = 0;
    end else begin
      for (int i = 0; i < 5; i++)
        if (k[4-i] && w < 0) w = i;
      if (w >= 0) begin
        if (nxt[m_st][w] >= 0) ns = nxt[m_st][w];
        if (m_st == 6 && w == 3) rdy = 1'b1;
      end
      if (m_st == 2 && ns == 2) begin
        if (w >= 0) m_cnt = 0;
        else if (m_cnt == T - 1) begin
          ns    = 3;
          m_cnt = 0;
        end else m_cnt = m_cnt + 1;
      end else begin
        m_cnt = 0;
      end
    end
    m_st = ns;
    exp_q.push_back({ftab[ns], (ns == 6), rdy, 3'(ns)});
    tag_q.push_back(cur_tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(K_NONE, 1'b0);
  endtask

  // Monitor: registered outputs are valid every cycle after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e_v = exp_q.pop_front();
        e_t = tag_q.pop_front();
        g_v = {CLK_R, TIME_R, PAUSE_R, STOP_R, CLEAR_R, PRE_R,
               alarm_set, alarm_ready, state_code};
        n_chk++;
        if (g_v === e_v) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)",
                      e_t, g_v, e_v, $time);
      end
    end
  end

  initial begin
    for (int s = 0; s < 7; s++)
      for (int k = 0; k < 5; k++) nxt[s][k] = -1;
    nxt[0][3] = 1; nxt[0][4] = 6;
    nxt[1][3] = 2; nxt[1][1] = 3;
    nxt[2][3] = 1; nxt[2][1] = 3;
    nxt[3][0] = 4; nxt[3][2] = 5; nxt[3][3] = 1; nxt[3][4] = 0;
    nxt[4][2] = 5; nxt[4][3] = 1; nxt[4][4] = 0;
    nxt[5][0] = 4; nxt[5][3] = 1; nxt[5][4] = 0;
    nxt[6][3] = 0; nxt[6][4] = 0;
    ftab[0] = 6'b100000; ftab[1] = 6'b110000;
    ftab[2] = 6'b111000; ftab[3] = 6'b110100;
    ftab[4] = 6'b110110; ftab[5] = 6'b110111;
    ftab[6] = 6'b000000;

    cur_tag = "reset";
    step(K_NONE, 1'b1);
    step(K_NONE, 1'b1);
    cur_tag = "idle_start";
    idle(4);
    step(K_STA, 1'b0);
    idle(1);
    cur_tag = "run_walk";
    step(K_STA, 1'b0);
    step(K_STA, 1'b0);
    step(K_STP, 1'b0);
    step(K_CLR, 1'b0);
    step(K_PRE, 1'b0);
    step(K_MOD, 1'b0);
    cur_tag = "timeout";
    step(K_STA, 1'b0);
    step(K_STA, 1'b0);
    idle(10);
    cur_tag = "timeout_restart";
    step(K_STA, 1'b0);
    step(K_STA, 1'b0);
    idle(5);
    step(K_PRE, 1'b0);
    idle(10);
    step(K_MOD, 1'b0);
    cur_tag = "alarm_confirm";
    step(K_MOD, 1'b0);
    idle(1);
    step(K_STA, 1'b0);
    idle(2);
    cur_tag = "alarm_exit";
    step(K_MOD, 1'b0);
    step(K_MOD, 1'b0);
    idle(2);
    cur_tag = "priority";
    step(K_STA, 1'b0);
    step(K_STP, 1'b0);
    step(K_CLR | K_PRE | K_STA, 1'b0);
    step(K_MOD, 1'b0);
    step(K_STA, 1'b0);
    step(K_PRE | K_STA, 1'b0);
    step(K_STP, 1'b0);
    step(K_MOD, 1'b0);
    cur_tag = "reset_in_alarm";
    step(K_MOD, 1'b0);
    step(K_STA, 1'b1);
    idle(2);
    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] k;
      logic       r;
      k = K_NONE;
      if ($urandom_range(0, 3) == 0) k = 5'($urandom_range(1, 31));
      r = ($urandom_range(0, 199) == 0);
      step(k, r);
    end
    idle(2);
    @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
